// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the synchronous-memory port of mem_arbiter.
// slave: arbiter side; master: environment side (requesters and memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_q,
        output gnt0, ack0, rdata0,
        output gnt1, ack1, rdata1,
        output mem_addr, mem_data, mem_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_q,
        input  gnt0, ack0, rdata0,
        input  gnt1, ack1, rdata1,
        input  mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one synchronous memory: each access is ACC -> CAPT -> ACK.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAPT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t            state_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              mem_we_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req_s;
    logic              win1_s;

`ifdef MEM_ARB_RR_EN
    logic              last_q;
`endif

    // Winner selection for the next IDLE sampling edge
    always_comb begin
        any_req_s = bus.req0 | bus.req1;
`ifdef MEM_ARB_RR_EN
        if (bus.req0 && bus.req1) begin
            win1_s = ~last_q;
        end else begin
            win1_s = bus.req1;
        end
`else
        if (bus.req0) begin
            win1_s = 1'b0;
        end else begin
            win1_s = bus.req1;
        end
`endif
    end

    // Access sequencer with registered grant, ack, memory and read-data outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        state_q    <= ACC;
                        gnt0_q     <= ~win1_s;
                        gnt1_q     <= win1_s;
                        mem_addr_q <= win1_s ? bus.addr1  : bus.addr0;
                        mem_data_q <= win1_s ? bus.wdata1 : bus.wdata0;
                        we_q       <= win1_s ? bus.we1    : bus.we0;
                        mem_we_q   <= win1_s ? bus.we1    : bus.we0;
`ifdef MEM_ARB_RR_EN
                        last_q     <= win1_s;
`endif
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                ACC: begin
                    mem_we_q <= 1'b0;
                    state_q  <= CAPT;
                end
                CAPT: begin
                    // mem_q now reflects the address presented during ACC
                    if (!we_q) begin
                        if (gnt1_q) begin
                            rdata1_q <= bus.mem_q;
                        end else begin
                            rdata0_q <= bus.mem_q;
                        end
                    end else begin
                        rdata0_q <= rdata0_q;
                    end
                    ack0_q  <= gnt0_q;
                    ack1_q  <= gnt1_q;
                    state_q <= ACK;
                end
                ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Synchronous memory: read data appears one edge after the address
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: ph counts cycles since the grant (0 = no access in flight)
    int            ph = 0;
    bit            who, twe, last;
    logic [AW-1:0] taddr, exp_maddr;
    logic [DW-1:0] twd, exp_mdata;
    logic [DW-1:0] exp_r [2];
    logic [DW-1:0] mm [256];

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = '0;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ph = 0; last = 1'b1;
                exp_maddr = '0; exp_mdata = '0;
                exp_r[0] = '0; exp_r[1] = '0;
            end
            chk("gnt0",     32'(bus.gnt0),   32'(ph != 0 && who == 1'b0));
            chk("gnt1",     32'(bus.gnt1),   32'(ph != 0 && who == 1'b1));
            chk("ack0",     32'(bus.ack0),   32'(ph == 3 && who == 1'b0));
            chk("ack1",     32'(bus.ack1),   32'(ph == 3 && who == 1'b1));
            chk("mem_we",   32'(bus.mem_we), 32'(ph == 1 && twe));
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
            chk("mem_data", 32'(bus.mem_data), 32'(exp_mdata));
            chk("rdata0",   32'(bus.rdata0), 32'(exp_r[0]));
            chk("rdata1",   32'(bus.rdata1), 32'(exp_r[1]));
            if (reset_n) begin
                case (ph)
                    0: if (bus.req0 || bus.req1) begin
                        if (bus.req0 && bus.req1) who = RR ? !last : 1'b0;
                        else                      who = bus.req1;
                        last  = who;
                        twe   = who ? bus.we1    : bus.we0;
                        taddr = who ? bus.addr1  : bus.addr0;
                        twd   = who ? bus.wdata1 : bus.wdata0;
                        exp_maddr = taddr;
                        exp_mdata = twd;
                        ph = 1;
                    end
                    1: begin
                        if (twe) mm[taddr] = twd;
                        ph = 2;
                    end
                    2: begin
                        if (!twe) exp_r[who] = mm[taddr];
                        ph = 3;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic do_access(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r) begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
        tick(); tick(); tick();
        chk("do_access_ack", r ? 32'(bus.ack1) : 32'(bus.ack0), 32'd1);
        if (r) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        tick();
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        repeat (3) @(posedge clk);
        #2;
        mem_clr = 1'b0;
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single write by requester 1
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h05; bus.wdata1 = 16'hBEEF;
        tick();
        chk("wr_c1_gnt1", 32'(bus.gnt1), 32'd1);
        chk("wr_c1_mem_we", 32'(bus.mem_we), 32'd1);
        chk("wr_c1_mem_addr", 32'(bus.mem_addr), 32'h05);
        chk("wr_c1_mem_data", 32'(bus.mem_data), 32'hBEEF);
        tick();
        chk("wr_c2_mem_we", 32'(bus.mem_we), 32'd0);
        chk("wr_c2_gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        chk("wr_c3_ack1", 32'(bus.ack1), 32'd1);
        chk("wr_c3_rdata1", 32'(bus.rdata1), 32'd0);
        bus.req1 = 1'b0;
        tick();
        chk("wr_idle_gnt1", 32'(bus.gnt1), 32'd0);

        // Read-back by requester 0
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
        tick();
        chk("rd_c1_gnt0", 32'(bus.gnt0), 32'd1);
        chk("rd_c1_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        tick();
        chk("rd_c3_ack0", 32'(bus.ack0), 32'd1);
        chk("rd_c3_rdata0", 32'(bus.rdata0), 32'hBEEF);
        bus.req0 = 1'b0;
        tick();

        // Contention from a fresh reset
        reset_n = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        reset_n = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("cont_gnt0", 32'(bus.gnt0), (RR && g % 2 == 1) ? 32'd0 : 32'd1);
            chk("cont_gnt1", 32'(bus.gnt1), (RR && g % 2 == 1) ? 32'd1 : 32'd0);
            tick(); tick();
            chk("cont_ack_any", 32'(bus.ack0 | bus.ack1), 32'd1);
            tick();
            chk("cont_idle_gap", 32'({bus.gnt0, bus.gnt1}), 32'd0);
            tick();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) tick();

        // Reset during ACC of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h33; bus.wdata0 = 16'h1234;
        tick();
        chk("abort_acc_we", 32'(bus.mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_gnt0", 32'(bus.gnt0), 32'd0);
        chk("abort_ack0", 32'(bus.ack0), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("abort_mem_data", 32'(bus.mem_data), 32'd0);
        chk("abort_rdata0", 32'(bus.rdata0), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h05;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_ack1", 32'(bus.ack1), 32'd1);
        chk("post_rst_rdata1", 32'(bus.rdata1), 32'hBEEF);
        bus.req1 = 1'b0;
        tick();
        do_access(1'b0, 1'b0, 8'h33, 16'h0000);
        chk("abort_no_write", 32'(bus.rdata0), 32'd0);

        // Address change during CAPT has no effect
        do_access(1'b1, 1'b1, 8'h10, 16'hA5A5);
        do_access(1'b1, 1'b1, 8'h20, 16'h5A5A);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        tick();
        tick();
        bus.addr0 = 8'h20;
        chk("chg_capt_mem_addr", 32'(bus.mem_addr), 32'h10);
        tick();
        chk("chg_ack0", 32'(bus.ack0), 32'd1);
        chk("chg_rdata0", 32'(bus.rdata0), 32'hA5A5);
        chk("chg_ack_mem_addr", 32'(bus.mem_addr), 32'h10);
        bus.req0 = 1'b0;
        tick();

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (bus.req0 && bus.ack0) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'($urandom_range(0, 1));
                bus.addr0 = 8'($urandom_range(0, 15)); bus.wdata0 = 16'($urandom);
            end
            if (bus.req1 && bus.ack1) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.we1 = 1'($urandom_range(0, 1));
                bus.addr1 = 8'($urandom_range(0, 15)); bus.wdata1 = 16'($urandom);
            end
            if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            tick();
        end
        reset_n = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
